// File: rtl/sseg_square_monitor_if.sv
// Snooped display bus (an/sseg from the square driver) plus the monitor's status outputs.
interface sseg_square_monitor_if;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_valid;
  logic [2:0] pos;
  logic       pos_valid;
  logic [1:0] dir;
  logic       stalled;
  logic       err;
  logic [7:0] err_cnt;

  modport master (output an, sseg,
                  input  frame_valid, pos, pos_valid, dir, stalled, err, err_cnt);
  modport slave  (input  an, sseg,
                  output frame_valid, pos, pos_valid, dir, stalled, err, err_cnt);
endinterface

// File: rtl/sseg_square_monitor.sv
// Rebuilds rotating-square frames from the multiplexed an/sseg bus and reports position/direction/stall/errors.
// Optional: define SSEG_MON_ERR_CNT_EN to enable the saturating err_cnt counter (otherwise err_cnt = 0).
module sseg_square_monitor #(
  parameter int STABLE_CYC   = 4,
  parameter int STALL_FRAMES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  sseg_square_monitor_if.slave  bus
);
  localparam logic [7:0] UP_SQ      = 8'h9C;
  localparam logic [7:0] LO_SQ      = 8'hA3;
  localparam logic [7:0] BLANK      = 8'hFF;
  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYC);
  localparam logic [7:0] STALL_LIM  = 8'(STALL_FRAMES);

  typedef enum logic [1:0] {S_SYNC, S_COLLECT, S_EVAL} state_e;

  state_e          state_q, state_d;
  logic [3:0][7:0] slot_q, slot_d;
  logic [3:0]      seen_q, seen_d;
  logic [3:0]      an_prev_q, an_prev_d;
  logic [7:0]      sseg_prev_q, sseg_prev_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            captured_q, captured_d;
  logic [2:0]      pos_q, pos_d;
  logic            pos_valid_q, pos_valid_d;
  logic [1:0]      dir_q, dir_d;
  logic [7:0]      stall_cnt_q, stall_cnt_d;
  logic            stalled_q, stalled_d;
  logic            have_prev_q, have_prev_d;
  logic            frame_valid_q, frame_valid_d;
  logic            err_q, err_d;

  logic       onehot, same, cap;
  logic [1:0] cap_dig;
  logic [2:0] n_sq, new_pos, step;
  logic       all_ok, legal;

  // Stability filter: one capture per an value once it has held unchanged long enough
  always_comb begin
    onehot = 1'b1;
    cap_dig = 2'd0;
    case (bus.an)
      4'b1110: cap_dig = 2'd0;
      4'b1101: cap_dig = 2'd1;
      4'b1011: cap_dig = 2'd2;
      4'b0111: cap_dig = 2'd3;
      default: onehot = 1'b0;
    endcase
    same        = (bus.an == an_prev_q) && (bus.sseg == sseg_prev_q);
    an_prev_d   = bus.an;
    sseg_prev_d = bus.sseg;
    cnt_d       = 8'd0;
    if (onehot && same)
      cnt_d = (cnt_q == STABLE_LIM) ? cnt_q : cnt_q + 8'd1;
    cap        = (cnt_d == STABLE_LIM) && !captured_q;
    captured_d = (!onehot || bus.an != an_prev_q) ? 1'b0 : (captured_q | cap);
  end

  // Frame legality: exactly one square, everything else blank (a lit dp fails both compares)
  always_comb begin
    n_sq    = 3'd0;
    all_ok  = 1'b1;
    new_pos = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (slot_q[i] == UP_SQ) begin
        n_sq    = n_sq + 3'd1;
        new_pos = 3'(3 - i);
      end else if (slot_q[i] == LO_SQ) begin
        n_sq    = n_sq + 3'd1;
        new_pos = 3'(4 + i);
      end else if (slot_q[i] != BLANK) begin
        all_ok = 1'b0;
      end
    end
    legal = all_ok && (n_sq == 3'd1);
    step  = new_pos - pos_q;
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    seen_d        = seen_q;
    pos_d         = pos_q;
    pos_valid_d   = pos_valid_q;
    dir_d         = dir_q;
    stall_cnt_d   = stall_cnt_q;
    have_prev_d   = have_prev_q;
    frame_valid_d = 1'b0;
    err_d         = 1'b0;
    case (state_q)
      S_SYNC: begin
        // The resync digit 0 is itself the first slot of the new frame
        if (cap && cap_dig == 2'd0) begin
          slot_d[0] = bus.sseg;
          seen_d    = 4'b0001;
          state_d   = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (cap) begin
          if (cap_dig == 2'd0 && seen_q != 4'b0000) begin
            err_d   = 1'b1;
            seen_d  = 4'b0000;
            state_d = S_SYNC;
          end else begin
            slot_d[cap_dig] = bus.sseg;
            seen_d[cap_dig] = 1'b1;
            if (seen_d == 4'b1111) state_d = S_EVAL;
          end
        end
      end
      S_EVAL: begin
        frame_valid_d = 1'b1;
        seen_d        = 4'b0000;
        state_d       = S_COLLECT;
        pos_valid_d   = legal;
        if (!legal) begin
          err_d = 1'b1;
        end else begin
          pos_d       = new_pos;
          have_prev_d = 1'b1;
          if (!have_prev_q) begin
            stall_cnt_d = 8'd0;
          end else if (step == 3'd0) begin
            if (stall_cnt_q != STALL_LIM) stall_cnt_d = stall_cnt_q + 8'd1;
          end else begin
            stall_cnt_d = 8'd0;
            if (step == 3'd1)      dir_d = 2'b01;
            else if (step == 3'd7) dir_d = 2'b10;
            else begin
              dir_d = 2'b11;
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_SYNC;
    endcase
    stalled_d = (stall_cnt_d == STALL_LIM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_SYNC;
      slot_q        <= {4{BLANK}};
      seen_q        <= 4'b0000;
      an_prev_q     <= 4'hF;
      sseg_prev_q   <= BLANK;
      cnt_q         <= 8'd0;
      captured_q    <= 1'b0;
      pos_q         <= 3'd0;
      pos_valid_q   <= 1'b0;
      dir_q         <= 2'b00;
      stall_cnt_q   <= 8'd0;
      stalled_q     <= 1'b0;
      have_prev_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      seen_q        <= seen_d;
      an_prev_q     <= an_prev_d;
      sseg_prev_q   <= sseg_prev_d;
      cnt_q         <= cnt_d;
      captured_q    <= captured_d;
      pos_q         <= pos_d;
      pos_valid_q   <= pos_valid_d;
      dir_q         <= dir_d;
      stall_cnt_q   <= stall_cnt_d;
      stalled_q     <= stalled_d;
      have_prev_q   <= have_prev_d;
      frame_valid_q <= frame_valid_d;
      err_q         <= err_d;
    end
  end

`ifdef SSEG_MON_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= 8'd0;
    else       err_cnt_q <= err_cnt_d;
  end
  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = 8'h00;
`endif

  assign bus.frame_valid = frame_valid_q;
  assign bus.pos         = pos_q;
  assign bus.pos_valid   = pos_valid_q;
  assign bus.dir         = dir_q;
  assign bus.stalled     = stalled_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_sseg_square_monitor.sv
// Directed-vector scoreboard bench for sseg_square_monitor (STABLE_CYC=4, STALL_FRAMES=16).
module tb_sseg_square_monitor;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sseg_square_monitor_if bus();
  sseg_square_monitor #(.STABLE_CYC(4), .STALL_FRAMES(16)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic       fv;
    logic       err;
    logic       pv;
    logic [2:0] pos;
    logic [1:0] dir;
    logic       st;
    logic [7:0] ec;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  errors = 0;
  int  exp_ec = 0;

  task automatic expect_ev(input logic fv, input logic err, input logic pv,
                           input logic [2:0] pos, input logic [1:0] dir, input logic st);
    ev_t e;
    if (err && exp_ec < 255) exp_ec++;
    e.fv = fv; e.err = err; e.pv = pv; e.pos = pos; e.dir = dir; e.st = st;
`ifdef SSEG_MON_ERR_CNT_EN
    e.ec = 8'(exp_ec);
`else
    e.ec = 8'h00;
`endif
    expq.push_back(e);
  endtask

  // Monitor: every frame_valid or err pulse must match the head of the queue
  initial begin
    ev_t got, e;
    forever begin
      @(negedge clk);
      if (!reset && (bus.frame_valid || bus.err)) begin
        got = '{bus.frame_valid, bus.err, bus.pos_valid, bus.pos, bus.dir, bus.stalled, bus.err_cnt};
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got fv=%0b err=%0b pv=%0b pos=%0d dir=%0d st=%0b ec=%0d",
                   got.fv, got.err, got.pv, got.pos, got.dir, got.st, got.ec);
        end else begin
          e = expq.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL event got fv=%0b err=%0b pv=%0b pos=%0d dir=%0d st=%0b ec=%0d expected fv=%0b err=%0b pv=%0b pos=%0d dir=%0d st=%0b ec=%0d",
                     got.fv, got.err, got.pv, got.pos, got.dir, got.st, got.ec,
                     e.fv, e.err, e.pv, e.pos, e.dir, e.st, e.ec);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_pos", 8'(bus.pos), 8'd0);
    chk("rst_pos_valid", 8'(bus.pos_valid), 8'd0);
    chk("rst_dir", 8'(bus.dir), 8'd0);
    chk("rst_stalled", 8'(bus.stalled), 8'd0);
    chk("rst_frame_valid", 8'(bus.frame_valid), 8'd0);
    chk("rst_err", 8'(bus.err), 8'd0);
    chk("rst_err_cnt", bus.err_cnt, 8'd0);
  endtask

  task automatic drive_digit(input int d, input logic [7:0] pat, input int cyc);
    logic [3:0] one;
    one = 4'b0001;
    bus.an   = ~(one << d);
    bus.sseg = pat;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0][7:0] frame_pat(input int p);
    logic [3:0][7:0] s;
    s = {4{8'hFF}};
    if (p < 4) s[3 - p] = 8'h9C;
    else       s[p - 4] = 8'hA3;
    return s;
  endfunction

  task automatic send_frame(input logic [3:0][7:0] s);
    for (int d = 0; d < 4; d++) drive_digit(d, s[d], 6);
  endtask

  task automatic send_pos(input int p);
    send_frame(frame_pat(p));
  endtask

  initial begin
    logic [3:0][7:0] fr;
    reset    = 1'b1;
    bus.an   = 4'hF;
    bus.sseg = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    @(posedge clk); #1;

    // cw lap 0..7 then wrap to 0
    expect_ev(1, 0, 1, 3'd0, 2'b00, 0); send_pos(0);
    for (int p = 1; p < 8; p++) begin
      expect_ev(1, 0, 1, 3'(p), 2'b01, 0); send_pos(p);
    end
    expect_ev(1, 0, 1, 3'd0, 2'b01, 0); send_pos(0);

    // 0->1->2 cw, then ccw 2->1->0->7->6->5
    expect_ev(1, 0, 1, 3'd1, 2'b01, 0); send_pos(1);
    expect_ev(1, 0, 1, 3'd2, 2'b01, 0); send_pos(2);
    expect_ev(1, 0, 1, 3'd1, 2'b10, 0); send_pos(1);
    expect_ev(1, 0, 1, 3'd0, 2'b10, 0); send_pos(0);
    expect_ev(1, 0, 1, 3'd7, 2'b10, 0); send_pos(7);
    expect_ev(1, 0, 1, 3'd6, 2'b10, 0); send_pos(6);
    expect_ev(1, 0, 1, 3'd5, 2'b10, 0); send_pos(5);

    // 16 repeats of pos 5: stalled on the 16th, then cleared by moving on
    for (int k = 1; k <= 16; k++) begin
      expect_ev(1, 0, 1, 3'd5, 2'b10, (k == 16)); send_pos(5);
    end
    expect_ev(1, 0, 1, 3'd6, 2'b01, 0); send_pos(6);
    expect_ev(1, 0, 1, 3'd7, 2'b01, 0); send_pos(7);
    expect_ev(1, 0, 1, 3'd0, 2'b01, 0); send_pos(0);
    expect_ev(1, 0, 1, 3'd1, 2'b01, 0); send_pos(1);

    // illegal jump 1->4, then a two-square frame
    expect_ev(1, 1, 1, 3'd4, 2'b11, 0); send_pos(4);
    fr = {8'hFF, 8'hA3, 8'hFF, 8'h9C};
    expect_ev(1, 1, 0, 3'd4, 2'b11, 0); send_frame(fr);
    expect_ev(1, 0, 1, 3'd5, 2'b01, 0); send_pos(5);
    // lit dp on an otherwise valid square
    fr = {8'hFF, 8'hFF, 8'h23, 8'hFF};
    expect_ev(1, 1, 0, 3'd5, 2'b01, 0); send_frame(fr);
    expect_ev(1, 0, 1, 3'd6, 2'b01, 0); send_pos(6);

    // short digit 2 plus a two-hot an: next digit 0 is a bad frame, then resync
    drive_digit(0, 8'hFF, 6);
    drive_digit(1, 8'hFF, 6);
    drive_digit(2, 8'hFF, 3);
    bus.an = 4'b1100; bus.sseg = 8'hFF;
    repeat (6) @(posedge clk); #1;
    drive_digit(3, 8'hFF, 6);
    expect_ev(0, 1, 1, 3'd6, 2'b01, 0);
    drive_digit(0, 8'hFF, 6);
    drive_digit(1, 8'hFF, 6);
    drive_digit(2, 8'hFF, 6);
    drive_digit(3, 8'hFF, 6);
    expect_ev(1, 0, 1, 3'd7, 2'b01, 0); send_pos(7);

    // reset after two digits of a frame
    drive_digit(0, 8'hFF, 6);
    drive_digit(1, 8'hFF, 6);
    drive_digit(2, 8'hFF, 2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    reset  = 1'b0;
    exp_ec = 0;
    @(posedge clk); #1;
    drive_digit(3, 8'hFF, 6);
    expect_ev(1, 0, 1, 3'd3, 2'b00, 0); send_pos(3);
    expect_ev(1, 0, 1, 3'd2, 2'b10, 0); send_pos(2);

    for (int i = 0; i < 50 && expq.size() != 0; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
